exe_unit_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational exe_unit between REQS independent requesters, for example several SPI front-ends.
- Arbitrates between requesters and latches the winner's operands and opcode.
- Drives the exe_unit operand bus, registers its result and flags, and returns them to the winner with a done pulse.
- exe_unit itself sits outside this block and connects through the o_exe_*/i_exe_* ports.

---
 rtl/exe_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/exe_unit_arbiter.sv | 167 ++++++++++++++++
 tb/tb_exe_unit_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_arb_pkg.sv
// Shared types and constants for the exe_unit arbiter and its round-robin picker.
package exe_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit positions inside the {BF,NF,OF,SF} flag word
   localparam int SF      = 0;
   localparam int OF      = 1;
   localparam int NF      = 2;
   localparam int BF      = 3;
   localparam int FLAGS_W = 4;

   // Index width that stays legal for a single requester
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo REQS.
// Zero latency; vld_o low (gnt_o all zero) when nothing is requested.
module rr_arbiter
   import exe_arb_pkg::*;
#(
   parameter int REQS = 2,
   parameter int IW   = idx_w(REQS)
)
(
   input  logic [REQS-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [REQS-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            vld_o
);

   int best;
   int off;
   int sel;

   // Distance from ptr_i, measured upward with wrap; the smallest distance wins
   always_comb begin
      gnt_o = '0;
      vld_o = 1'b0;
      best  = REQS;
      off   = 0;
      sel   = 0;
      for (int k = 0; k < REQS; k++) begin
         off = k - int'(ptr_i);
         if (off < 0) begin
            off = off + REQS;
         end
         if (req_i[k] && (off < best)) begin
            best     = off;
            sel      = k;
            gnt_o    = '0;
            gnt_o[k] = 1'b1;
            vld_o    = 1'b1;
         end
      end
      idx_o = IW'(sel);
   end

endmodule

// File: rtl/exe_unit_arbiter.sv
// Round-robin share of one external exe_unit among REQS requesters; 3 cycles per op (grant, exec, done).
// No backpressure: requesters hold i_req/operands until o_gnt; EXE_ARB_STATS_EN adds op and grant counters.
module exe_unit_arbiter
   import exe_arb_pkg::*;
#(
   parameter int REQS = 2,
   parameter int M    = 8,
   parameter int N    = 4
)
(
   input  logic                 i_clk_p,
   input  logic                 i_rst_n,
   input  logic [REQS-1:0]      i_req,
   input  logic [REQS*M-1:0]    i_argA,
   input  logic [REQS*M-1:0]    i_argB,
   input  logic [REQS*N-1:0]    i_oper,
   output logic [REQS-1:0]      o_gnt,
   output logic [REQS-1:0]      o_done,
   output logic [M-1:0]         o_result,
   output logic [FLAGS_W-1:0]   o_flags,
   output logic                 o_busy,
   output logic [M-1:0]         o_exe_argA,
   output logic [M-1:0]         o_exe_argB,
   output logic [N-1:0]         o_exe_oper,
   input  logic [M-1:0]         i_exe_result,
   input  logic [FLAGS_W-1:0]   i_exe_flags
`ifdef EXE_ARB_STATS_EN
   ,
   output logic [15:0]          o_op_cnt,
   output logic [REQS*8-1:0]    o_gnt_cnt
`endif
);

   localparam int IW = idx_w(REQS);

   if ((REQS < 1) || (REQS > 8)) begin : g_bad_reqs
      $error("exe_unit_arbiter: REQS must be within 1..8");
   end

   state_e               state_q;
   logic [IW-1:0]        ptr_q;
   logic [IW-1:0]        ptr_d;
   logic [IW-1:0]        win_q;
   logic [M-1:0]         arga_q;
   logic [M-1:0]         argb_q;
   logic [N-1:0]         oper_q;
   logic [REQS-1:0]      gnt_q;
   logic [REQS-1:0]      done_q;
   logic [M-1:0]         result_q;
   logic [FLAGS_W-1:0]   flags_q;
   logic                 busy_q;

   logic [REQS-1:0]      arb_gnt;
   logic [IW-1:0]        arb_idx;
   logic                 arb_vld;
   logic [M-1:0]         sel_a;
   logic [M-1:0]         sel_b;
   logic [N-1:0]         sel_op;

   rr_arbiter #(
      .REQS (REQS),
      .IW   (IW)
   ) u_rr (
      .req_i (i_req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   // One-hot grant steers the winner's operand lanes
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int k = 0; k < REQS; k++) begin
         if (arb_gnt[k]) begin
            sel_a  = i_argA[k*M +: M];
            sel_b  = i_argB[k*M +: M];
            sel_op = i_oper[k*N +: N];
         end
      end
   end

   assign ptr_d = (int'(win_q) == (REQS - 1)) ? '0 : win_q + 1'b1;

   always_ff @(posedge i_clk_p or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         win_q    <= '0;
         arga_q   <= '0;
         argb_q   <= '0;
         oper_q   <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
         flags_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_vld) begin
                  arga_q  <= sel_a;
                  argb_q  <= sel_b;
                  oper_q  <= sel_op;
                  win_q   <= arb_idx;
                  gnt_q   <= arb_gnt;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               result_q <= i_exe_result;
               flags_q  <= i_exe_flags;
               gnt_q    <= '0;
               done_q   <= gnt_q;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= '0;
               busy_q  <= 1'b0;
               ptr_q   <= ptr_d;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_gnt      = gnt_q;
   assign o_done     = done_q;
   assign o_result   = result_q;
   assign o_flags    = flags_q;
   assign o_busy     = busy_q;
   assign o_exe_argA = arga_q;
   assign o_exe_argB = argb_q;
   assign o_exe_oper = oper_q;

`ifdef EXE_ARB_STATS_EN
   logic [15:0]           op_cnt_q;
   logic [REQS-1:0][7:0]  gnt_cnt_q;

   // Ops are counted on entry to DONE, grants on the IDLE capture edge
   always_ff @(posedge i_clk_p or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_cnt_q  <= '0;
         gnt_cnt_q <= '0;
      end else begin
         if ((state_q == EXEC) && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_q <= op_cnt_q + 16'd1;
         end
         for (int k = 0; k < REQS; k++) begin
            if ((state_q == IDLE) && arb_gnt[k] && (gnt_cnt_q[k] != 8'hFF)) begin
               gnt_cnt_q[k] <= gnt_cnt_q[k] + 8'd1;
            end
         end
      end
   end

   assign o_op_cnt  = op_cnt_q;
   assign o_gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// Directed bench for exe_unit_arbiter with an adder stub as exe_unit and a per-cycle reference model.
module tb_exe_unit_arbiter;
   import exe_arb_pkg::*;

   localparam int REQS = 2;
   localparam int M    = 8;
   localparam int N    = 4;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b1;
   logic          cmp_on = 1'b0;
   logic [1:0]    req;
   logic [15:0]   argA;
   logic [15:0]   argB;
   logic [7:0]    oper;
   logic [1:0]    o_gnt;
   logic [1:0]    o_done;
   logic [7:0]    o_result;
   logic [3:0]    o_flags;
   logic          o_busy;
   logic [7:0]    o_exe_argA;
   logic [7:0]    o_exe_argB;
   logic [3:0]    o_exe_oper;
   logic [7:0]    exe_result;
   logic [3:0]    exe_flags;
`ifdef EXE_ARB_STATS_EN
   logic [15:0]   o_op_cnt;
   logic [15:0]   o_gnt_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // exe_unit stand-in: sum of the operands, SF when the sum is zero
   assign exe_result = o_exe_argA + o_exe_argB;
   always_comb begin
      exe_flags     = '0;
      exe_flags[SF] = (exe_result == 8'h00);
   end

   exe_unit_arbiter #(.REQS(REQS), .M(M), .N(N)) dut (
      .i_clk_p      (clk),
      .i_rst_n      (rst_n),
      .i_req        (req),
      .i_argA       (argA),
      .i_argB       (argB),
      .i_oper       (oper),
      .o_gnt        (o_gnt),
      .o_done       (o_done),
      .o_result     (o_result),
      .o_flags      (o_flags),
      .o_busy       (o_busy),
      .o_exe_argA   (o_exe_argA),
      .o_exe_argB   (o_exe_argB),
      .o_exe_oper   (o_exe_oper),
      .i_exe_result (exe_result),
      .i_exe_flags  (exe_flags)
`ifdef EXE_ARB_STATS_EN
      ,
      .o_op_cnt     (o_op_cnt),
      .o_gnt_cnt    (o_gnt_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int pick(input logic [1:0] r, input int p);
      for (int i = 0; i < REQS; i++) begin
         if (((32'(r) >> ((p + i) % REQS)) & 32'd1) != 32'd0) return (p + i) % REQS;
      end
      return -1;
   endfunction

   function automatic logic [7:0] lane8(input logic [15:0] v, input int k);
      return 8'(v >> (8 * k));
   endfunction

   function automatic logic [3:0] lane4(input logic [7:0] v, input int k);
      return 4'(v >> (4 * k));
   endfunction

   function automatic logic [3:0] flags_of(input logic [7:0] r);
      logic [3:0] f;
      f     = '0;
      f[SF] = (r == 8'h00);
      return f;
   endfunction

   int         m_phase;
   int         m_ptr;
   int         m_w;
   logic [7:0] m_a, m_b, m_res;
   logic [3:0] m_op, m_flg;
   logic [1:0] m_gnt, m_done;
   logic       m_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_ptr <= 0; m_w <= 0;
         m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0; m_flg <= '0;
         m_gnt <= '0; m_done <= '0; m_busy <= 1'b0;
      end else if (m_phase == 0) begin
         if (pick(req, m_ptr) >= 0) begin
            m_w     <= pick(req, m_ptr);
            m_a     <= lane8(argA, pick(req, m_ptr));
            m_b     <= lane8(argB, pick(req, m_ptr));
            m_op    <= lane4(oper, pick(req, m_ptr));
            m_gnt   <= 2'(1 << pick(req, m_ptr));
            m_busy  <= 1'b1;
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         m_res   <= m_a + m_b;
         m_flg   <= flags_of(m_a + m_b);
         m_gnt   <= '0;
         m_done  <= 2'(1 << m_w);
         m_phase <= 2;
      end else begin
         m_done  <= '0;
         m_busy  <= 1'b0;
         m_ptr   <= (m_w + 1) % REQS;
         m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("cyc_gnt",    32'(o_gnt),      32'(m_gnt));
         check("cyc_done",   32'(o_done),     32'(m_done));
         check("cyc_result", 32'(o_result),   32'(m_res));
         check("cyc_flags",  32'(o_flags),    32'(m_flg));
         check("cyc_busy",   32'(o_busy),     32'(m_busy));
         check("cyc_exe_a",  32'(o_exe_argA), 32'(m_a));
         check("cyc_exe_b",  32'(o_exe_argB), 32'(m_b));
         check("cyc_exe_op", 32'(o_exe_oper), 32'(m_op));
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed stimulus ----------------
   logic [31:0] gseq;
   int          cnt;

   initial begin
      req = '0; argA = '0; argB = '0; oper = '0;
      #1;
      rst_n  = 1'b0;
      cmp_on = 1'b1;

      check("pick_wrap",  32'(pick(2'b11, 1)), 32'd1);
      check("pick_lone",  32'(pick(2'b01, 1)), 32'd0);
      check("pick_none",  32'(pick(2'b00, 0)), 32'hFFFF_FFFF);

      @(negedge clk);
      check("rst_gnt",    32'(o_gnt),    32'h0);
      check("rst_busy",   32'(o_busy),   32'h0);
      check("rst_result", 32'(o_result), 32'h0);
      check("rst_exe_a",  32'(o_exe_argA), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy",  32'(o_busy), 32'h0);

      // single requester
      req = 2'b01; argA[7:0] = 8'h12; argB[7:0] = 8'h34; oper[3:0] = 4'h1;
      @(negedge clk);
      check("t1_gnt",     32'(o_gnt),      32'h1);
      check("t1_busy_e",  32'(o_busy),     32'h1);
      check("t1_exe_a",   32'(o_exe_argA), 32'h12);
      check("t1_exe_op",  32'(o_exe_oper), 32'h1);
      req = 2'b00;
      @(negedge clk);
      check("t1_done",    32'(o_done),     32'h1);
      check("t1_result",  32'(o_result),   32'h46);
      check("t1_sf",      32'(o_flags[SF]), 32'h0);
      check("t1_busy_d",  32'(o_busy),     32'h1);
      @(negedge clk);
      check("t1_busy_i",  32'(o_busy),     32'h0);
      check("t1_done_i",  32'(o_done),     32'h0);

      // contention from pointer 0, then request drop in DONE
      do_reset();
      argA = {8'hFF, 8'h01}; argB = {8'h01, 8'h02}; oper = 8'h52; req = 2'b11;
      gseq = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (o_gnt != 2'b00) gseq = (gseq << 2) | 32'(o_gnt);
         if (c == 2) begin
            check("t2_res0",  32'(o_result), 32'h03);
            check("t2_flg0",  32'(o_flags),  32'h0);
         end
         if (c == 5) begin
            check("t2_res1",  32'(o_result), 32'h00);
            check("t2_flg1",  32'(o_flags),  32'h1);
         end
         if (c == 11) begin
            check("t2_done4", 32'(o_done), 32'h2);
            req = 2'b00;
         end
      end
      check("t2_order", gseq, 32'h66);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t5_gnt",    32'(o_gnt),    32'h0);
         check("t5_busy",   32'(o_busy),   32'h0);
         check("t5_result", 32'(o_result), 32'h00);
      end

      // operand change after grant
      req = 2'b01; argA[7:0] = 8'h10; argB[7:0] = 8'h05; oper[3:0] = 4'h3;
      @(negedge clk);
      check("t3_gnt",     32'(o_gnt),      32'h1);
      check("t3_exe_a0",  32'(o_exe_argA), 32'h10);
      argA[7:0] = 8'h99;
      #4;
      check("t3_exe_a1",  32'(o_exe_argA), 32'h10);
      req = 2'b00;
      @(negedge clk);
      check("t3_done",    32'(o_done),   32'h1);
      check("t3_result",  32'(o_result), 32'h15);
      @(negedge clk);

      // reset during EXEC
      req = 2'b01; argA[7:0] = 8'h33; argB[7:0] = 8'h44;
      @(negedge clk);
      check("t4_gnt0",    32'(o_gnt), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_rst_gnt",  32'(o_gnt),      32'h0);
      check("t4_rst_busy", 32'(o_busy),     32'h0);
      check("t4_rst_res",  32'(o_result),   32'h0);
      check("t4_rst_flg",  32'(o_flags),    32'h0);
      check("t4_rst_exe",  32'(o_exe_argA), 32'h0);
      check("t4_rst_done", 32'(o_done),     32'h0);
      req = 2'b10; argA[15:8] = 8'h07; argB[15:8] = 8'h08;
      @(negedge clk);
      rst_n = 1'b1;
      check("t4_nodone",  32'(o_done), 32'h0);
      @(negedge clk);
      check("t4_gnt1",    32'(o_gnt),  32'h2);
      check("t4_nodone2", 32'(o_done), 32'h0);
      req = 2'b00;
      @(negedge clk);
      check("t4_done1",   32'(o_done),   32'h2);
      check("t4_result",  32'(o_result), 32'h0F);
      @(negedge clk);

`ifdef EXE_ARB_STATS_EN
      do_reset();
      req = 2'b01; argA[7:0] = 8'h01; argB[7:0] = 8'h01;
      cnt = 0;
      for (int c = 0; (c < 1200) && (cnt < 300); c++) begin
         @(negedge clk);
         if (o_done[0]) cnt++;
      end
      req = 2'b00;
      check("st_ops_seen", 32'(cnt),              32'd300);
      check("st_op_cnt",   32'(o_op_cnt),         32'd300);
      check("st_gnt_cnt0", 32'(o_gnt_cnt[7:0]),   32'hFF);
      check("st_gnt_cnt1", 32'(o_gnt_cnt[15:8]),  32'h00);
      @(negedge clk);
`endif

      @(negedge clk);
      cmp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
